rip_axi_arbiter: RTL



---
 rtl/rip_axi_arbiter.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rip_axi_arbiter.sv
// rip_axi_arbiter: round-robin sharing of the AXI master engine's line-wide
// read and write command interfaces between NUM_PORTS requesters. The read
// and write channels are independent, and each has one outstanding
// transaction at a time.
module rip_axi_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    // requester write side
    input  logic [NUM_PORTS-1:0]              wreq,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   waddr_in,
    input  logic [NUM_PORTS*LINE_SIZE*8-1:0]  wdata_in,
    input  logic [NUM_PORTS*LINE_SIZE-1:0]    wstrb_in,
    output logic [NUM_PORTS-1:0]              wack,
    output logic [NUM_PORTS-1:0]              wdone_out,
    // requester read side
    input  logic [NUM_PORTS-1:0]              rreq,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   raddr_in,
    output logic [NUM_PORTS-1:0]              rack,
    output logic [NUM_PORTS-1:0]              rdone_out,
    output logic [LINE_SIZE*8-1:0]            rdata_out,
    // master write command
    output logic [ADDR_WIDTH-1:0]             m_waddr,
    output logic [LINE_SIZE*8-1:0]            m_wdata,
    output logic [LINE_SIZE-1:0]              m_wstrb,
    output logic                              m_wvalid,
    input  logic                              m_wready,
    input  logic                              m_wdone,
    // master read command
    output logic [ADDR_WIDTH-1:0]             m_raddr,
    output logic                              m_rvalid,
    input  logic                              m_rready,
    input  logic                              m_rdone,
    input  logic [LINE_SIZE*8-1:0]            m_rdata
);

    localparam int DW = LINE_SIZE * 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } chan_state_e;

    // First requesting port at or above ptr, wrapping at NUM_PORTS.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [PW-1:0]        ptr);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
        return pick;
    endfunction

    // Port after g, wrapping explicitly so non-power-of-two counts work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
        return (g == PW'(NUM_PORTS - 1)) ? '0 : g + PW'(1);
    endfunction

    // Per-port views of the packed request payload buses.
    logic [ADDR_WIDTH-1:0] waddr_arr_s [NUM_PORTS];
    logic [DW-1:0]         wdata_arr_s [NUM_PORTS];
    logic [LINE_SIZE-1:0]  wstrb_arr_s [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] raddr_arr_s [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        // Slice port i out of each packed bus.
        assign waddr_arr_s[i] = waddr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr_s[i] = wdata_in[i*DW +: DW];
        assign wstrb_arr_s[i] = wstrb_in[i*LINE_SIZE +: LINE_SIZE];
        assign raddr_arr_s[i] = raddr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    chan_state_e            w_state_q, w_state_d;
    logic [PW-1:0]          w_ptr_q, w_ptr_d;
    logic [PW-1:0]          w_gnt_q, w_gnt_d;
    logic [PW-1:0]          w_pick_s;
    logic [ADDR_WIDTH-1:0]  m_waddr_q, m_waddr_d;
    logic [DW-1:0]          m_wdata_q, m_wdata_d;
    logic [LINE_SIZE-1:0]   m_wstrb_q, m_wstrb_d;
    logic                   m_wvalid_q, m_wvalid_d;
    logic [NUM_PORTS-1:0]   wack_q, wack_d;
    logic [NUM_PORTS-1:0]   wdone_q, wdone_d;

    assign w_pick_s = rr_pick(wreq, w_ptr_q);

    // Write FSM: grant, hold the command until accepted, then wait for done.
    always_comb begin
        w_state_d  = w_state_q;
        w_ptr_d    = w_ptr_q;
        w_gnt_d    = w_gnt_q;
        m_waddr_d  = m_waddr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        m_wvalid_d = m_wvalid_q;
        wack_d     = '0;
        wdone_d    = '0;
        case (w_state_q)
            ST_IDLE: begin
                if (|wreq) begin
                    m_waddr_d          = waddr_arr_s[w_pick_s];
                    m_wdata_d          = wdata_arr_s[w_pick_s];
                    m_wstrb_d          = wstrb_arr_s[w_pick_s];
                    m_wvalid_d         = 1'b1;
                    w_gnt_d            = w_pick_s;
                    wack_d[w_pick_s]   = 1'b1;
                    w_state_d          = ST_ISSUE;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_wready) begin
                    m_wvalid_d = 1'b0;
                    if (m_wdone) begin
                        // accepted and completed in the same cycle
                        wdone_d[w_gnt_q] = 1'b1;
                        w_ptr_d          = ptr_next(w_gnt_q);
                        w_state_d        = ST_IDLE;
                    end else begin
                        w_state_d = ST_WAIT_DONE;
                    end
                end else begin
                    w_state_d = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (m_wdone) begin
                    wdone_d[w_gnt_q] = 1'b1;
                    w_ptr_d          = ptr_next(w_gnt_q);
                    w_state_d        = ST_IDLE;
                end else begin
                    w_state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                m_wvalid_d = 1'b0;
                w_state_d  = ST_IDLE;
            end
        endcase
    end

    // Write channel registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= ST_IDLE;
            w_ptr_q    <= '0;
            w_gnt_q    <= '0;
            m_waddr_q  <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            m_wvalid_q <= 1'b0;
            wack_q     <= '0;
            wdone_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            w_ptr_q    <= w_ptr_d;
            w_gnt_q    <= w_gnt_d;
            m_waddr_q  <= m_waddr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            m_wvalid_q <= m_wvalid_d;
            wack_q     <= wack_d;
            wdone_q    <= wdone_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    chan_state_e            r_state_q, r_state_d;
    logic [PW-1:0]          r_ptr_q, r_ptr_d;
    logic [PW-1:0]          r_gnt_q, r_gnt_d;
    logic [PW-1:0]          r_pick_s;
    logic [ADDR_WIDTH-1:0]  m_raddr_q, m_raddr_d;
    logic                   m_rvalid_q, m_rvalid_d;
    logic [NUM_PORTS-1:0]   rack_q, rack_d;
    logic [NUM_PORTS-1:0]   rdone_q, rdone_d;
    logic [DW-1:0]          rdata_q, rdata_d;

    assign r_pick_s = rr_pick(rreq, r_ptr_q);

    // Read FSM: same flow as write, plus capture of the returned line.
    always_comb begin
        r_state_d  = r_state_q;
        r_ptr_d    = r_ptr_q;
        r_gnt_d    = r_gnt_q;
        m_raddr_d  = m_raddr_q;
        m_rvalid_d = m_rvalid_q;
        rack_d     = '0;
        rdone_d    = '0;
        rdata_d    = rdata_q;
        case (r_state_q)
            ST_IDLE: begin
                if (|rreq) begin
                    m_raddr_d        = raddr_arr_s[r_pick_s];
                    m_rvalid_d       = 1'b1;
                    r_gnt_d          = r_pick_s;
                    rack_d[r_pick_s] = 1'b1;
                    r_state_d        = ST_ISSUE;
                end else begin
                    r_state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_rready) begin
                    m_rvalid_d = 1'b0;
                    if (m_rdone) begin
                        rdone_d[r_gnt_q] = 1'b1;
                        rdata_d          = m_rdata;
                        r_ptr_d          = ptr_next(r_gnt_q);
                        r_state_d        = ST_IDLE;
                    end else begin
                        r_state_d = ST_WAIT_DONE;
                    end
                end else begin
                    r_state_d = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (m_rdone) begin
                    rdone_d[r_gnt_q] = 1'b1;
                    rdata_d          = m_rdata;
                    r_ptr_d          = ptr_next(r_gnt_q);
                    r_state_d        = ST_IDLE;
                end else begin
                    r_state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                m_rvalid_d = 1'b0;
                r_state_d  = ST_IDLE;
            end
        endcase
    end

    // Read channel registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_ptr_q    <= '0;
            r_gnt_q    <= '0;
            m_raddr_q  <= '0;
            m_rvalid_q <= 1'b0;
            rack_q     <= '0;
            rdone_q    <= '0;
            rdata_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_ptr_q    <= r_ptr_d;
            r_gnt_q    <= r_gnt_d;
            m_raddr_q  <= m_raddr_d;
            m_rvalid_q <= m_rvalid_d;
            rack_q     <= rack_d;
            rdone_q    <= rdone_d;
            rdata_q    <= rdata_d;
        end
    end

    // Every output comes straight from a flop.
    assign wack      = wack_q;
    assign wdone_out = wdone_q;
    assign m_waddr   = m_waddr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wstrb   = m_wstrb_q;
    assign m_wvalid  = m_wvalid_q;
    assign rack      = rack_q;
    assign rdone_out = rdone_q;
    assign rdata_out = rdata_q;
    assign m_raddr   = m_raddr_q;
    assign m_rvalid  = m_rvalid_q;

endmodule
